// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the arbitrated shift-add multiplier: FSM state
// type and its encoding.
package mult_arbiter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/shift_add_core.sv
// Unsigned radix-2 shift-add multiplier datapath. The product register starts
// as {0, b}; each step conditionally adds the multiplicand to the upper half
// (carry kept in an N+1 bit sum) and shifts the whole register right by one.
// After N steps it holds a*b.
module shift_add_core #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product
);

  logic [N-1:0] mcand;
  logic [N:0]   sum;

  // Partial sum of the upper half plus the multiplicand when the LSB is set.
  always_comb begin
    sum = {1'b0, product[2*N-1:N]} + (product[0] ? {1'b0, mcand} : '0);
  end

  // Load operands, then one shift-add step per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
      mcand   <= '0;
    end else if (load) begin
      product <= {{N{1'b0}}, b};
      mcand   <= a;
    end else if (step) begin
      product <= {sum, product[N-1:1]};
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared shift-add multiplier.
// Optional feature: define MULT_ARBITER_ZERO_BYPASS_EN to skip the multiply
// when either accepted operand is zero (result 0, one-cycle latency).
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int IW = (M < 2) ? 1 : $clog2(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M-1:0]   req_valid,
  input  logic [M*N-1:0] req_a,
  input  logic [M*N-1:0] req_b,
  output logic [M-1:0]   req_ready,
  output logic           rsp_valid,
  output logic [IW-1:0]  rsp_id,
  output logic [2*N-1:0] rsp_p,
  input  logic           rsp_ready
);

  localparam int CW = (N < 2) ? 1 : $clog2(N);

  state_t          state, state_d;
  logic [IW-1:0]   rr_ptr, next_ptr;
  logic [IW-1:0]   grant_idx, scan_idx, id_q;
  logic [M-1:0]    grant;
  logic            found, accept, load, step;
  logic [N-1:0]    sel_a, sel_b, op_a, op_b;
  logic [CW-1:0]   cnt;
  logic [2*N-1:0]  product;
  logic            bypass_hit;

  // Round-robin search starting at rr_ptr, wrapping modulo M.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int k = 0; k < M; k++) begin
      scan_idx = IW'((int'(rr_ptr) + k) % M);
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
    grant[grant_idx] = found;
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < M; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
      end
    end
  end

  assign next_ptr = (grant_idx == IW'(M-1)) ? '0 : grant_idx + 1'b1;

`ifdef MULT_ARBITER_ZERO_BYPASS_EN
  logic zero_in, zero_q;
  assign zero_in    = (sel_a == '0) || (sel_b == '0);
  assign bypass_hit = zero_q;
`else
  assign bypass_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic and core control strobes.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          accept  = 1'b1;
          state_d = LOAD;
`ifdef MULT_ARBITER_ZERO_BYPASS_EN
          if (zero_in) state_d = DONE;
`endif
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(N-1)) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the accepted request, advance the pointer, count RUN steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      id_q   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
`ifdef MULT_ARBITER_ZERO_BYPASS_EN
      zero_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rr_ptr <= next_ptr;
        id_q   <= grant_idx;
        op_a   <= sel_a;
        op_b   <= sel_b;
`ifdef MULT_ARBITER_ZERO_BYPASS_EN
        zero_q <= zero_in;
`endif
      end
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
    end
  end

  shift_add_core #(.N(N)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .a       (op_a),
    .b       (op_b),
    .product (product)
  );

  // Grants are suppressed while reset is held so nothing is offered before release.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign rsp_valid = (state == DONE);
  assign rsp_id    = (state == DONE) ? id_q : '0;
  assign rsp_p     = (state == DONE && !bypass_hit) ? product : '0;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter (N=4, M=4). Expected grants come from a
// round-robin pointer model, expected products from plain multiplication.
// Honours MULT_ARBITER_ZERO_BYPASS_EN for the expected latency.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int IW = 2;
  localparam int PW = 2 * N;
  localparam int BW = M * N;

  logic          clk;
  logic          rst_n;
  logic [M-1:0]  req_valid;
  logic [BW-1:0] req_a;
  logic [BW-1:0] req_b;
  logic [M-1:0]  req_ready;
  logic          rsp_valid;
  logic [IW-1:0] rsp_id;
  logic [PW-1:0] rsp_p;
  logic          rsp_ready;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  mult_arbiter #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference arbitration rule: first valid requester at or after ptr, modulo M.
  function automatic int pick(input logic [M-1:0] mask, input int ptr);
    for (int k = 0; k < M; k++) begin
      if (((mask >> ((ptr + k) % M)) & M'(1)) != '0) return (ptr + k) % M;
    end
    return -1;
  endfunction

  function automatic logic [BW-1:0] place(input logic [BW-1:0] bus, input int id, input int val);
    logic [BW-1:0] slot_mask;
    slot_mask = BW'((1 << N) - 1) << (id * N);
    return (bus & ~slot_mask) | (BW'(val) << (id * N));
  endfunction

  // One request/response transaction; starts and ends just after a falling edge.
  task automatic run_txn(input logic [M-1:0] mask, input logic [BW-1:0] a_bus,
                         input logic [BW-1:0] b_bus, input int stall, input bit hold,
                         output int got_id);
    int            exp_id, lat, exp_lat, waited;
    logic [N-1:0]  ea, eb;
    logic [PW-1:0] exp_p;
    logic [M-1:0]  exp_grant;
    got_id    = -1;
    req_valid = mask;
    req_a     = a_bus;
    req_b     = b_bus;
    rsp_ready = (stall == 0);
    #1;
    exp_id    = pick(mask, model_ptr);
    exp_grant = M'(1) << exp_id;
    waited    = 0;
    while (req_ready == '0 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    checks++;
    if (req_ready !== exp_grant) begin
      errors++;
      $display("FAIL grant: req_ready=%b expected %b (mask %b)", req_ready, exp_grant, mask);
      req_valid = '0;
      return;
    end
    ea    = N'(a_bus >> (exp_id * N));
    eb    = N'(b_bus >> (exp_id * N));
    exp_p = PW'(ea) * PW'(eb);
`ifdef MULT_ARBITER_ZERO_BYPASS_EN
    exp_lat = (ea == '0 || eb == '0) ? 1 : N + 2;
`else
    exp_lat = N + 2;
`endif
    model_ptr = (exp_id + 1) % M;

    @(negedge clk);
    if (!hold) begin
      req_valid = '0;
      req_a     = BW'($urandom);
      req_b     = BW'($urandom);
    end
    #1;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL busy_ready: req_ready=%b expected 0 while busy", req_ready);
      end
      @(negedge clk); #1; lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected %0d", lat, exp_lat);
      if (rsp_valid !== 1'b1) return;
    end
    got_id = int'(rsp_id);
    checks++;
    if (rsp_p !== exp_p || rsp_id !== IW'(exp_id)) begin
      errors++;
      $display("FAIL result: p=%0d id=%0d expected p=%0d id=%0d (a=%0d b=%0d)",
               rsp_p, rsp_id, exp_p, exp_id, ea, eb);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== exp_p || rsp_id !== IW'(exp_id) || req_ready !== '0) begin
        errors++;
        $display("FAIL hold: valid=%b p=%0d id=%0d ready=%b expected valid=1 p=%0d id=%0d ready=0",
                 rsp_valid, rsp_p, rsp_id, req_ready, exp_p, exp_id);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: rsp_valid=%b expected 0 after handshake", rsp_valid);
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_p !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b id=%0d p=%0d expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_p);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    model_ptr = 0;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b valid=%b expected 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_idle();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_req: ready=%b valid=%b expected 0", req_ready, rsp_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int got;
    logic [BW-1:0] a_bus, b_bus;
    for (int k = 0; k < 5; k++) begin
      a_bus = BW'($urandom);
      b_bus = BW'($urandom);
      run_txn('1, a_bus, b_bus, 0, 1'b1, got);
      checks++;
      if (got !== order[k]) begin
        errors++;
        $display("FAIL rr_order: grant %0d got id %0d expected %0d", k, got, order[k]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    int got;
    run_txn(4'b0100, place('0, 2, 15), place('0, 2, 15), 0, 1'b0, got);
    checks++;
    if (got !== 2) begin
      errors++;
      $display("FAIL single_id: got %0d expected 2", got);
    end
  endtask

  task automatic test_backpressure();
    int got;
    run_txn(4'b0010, place(BW'($urandom), 1, 7), place(BW'($urandom), 1, 9), 5, 1'b0, got);
  endtask

  task automatic test_reset_in_run();
    int got;
    req_valid = 4'b0001;
    req_a     = place('0, 0, 9);
    req_b     = place('0, 0, 11);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_run_grant: req_ready=%b expected 0001", req_ready);
    end
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_p !== '0) begin
      errors++;
      $display("FAIL rst_run_outputs: ready=%b valid=%b id=%0d p=%0d expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_p);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    model_ptr = 0;
    #1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_result: rsp_valid=%b p=%0d expected no response", rsp_valid, rsp_p);
      end
      @(negedge clk); #1;
    end
    run_txn(4'b1000, place('0, 3, 3), place('0, 3, 5), 0, 1'b0, got);
  endtask

  task automatic test_zero();
    int got;
    run_txn(4'b0001, place(BW'($urandom), 0, 0), place(BW'($urandom), 0, 13), 0, 1'b0, got);
    run_txn(4'b0100, place(BW'($urandom), 2, 6), place(BW'($urandom), 2, 0), 1, 1'b0, got);
  endtask

  task automatic test_exhaustive();
    int id, got;
    logic [M-1:0] mask;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        id   = (a * 16 + b) % M;
        mask = M'(1) << id;
        run_txn(mask, place(BW'($urandom), id, a), place(BW'($urandom), id, b),
                int'($urandom_range(0, 2)), 1'b0, got);
        checks++;
        if (got !== id) begin
          errors++;
          $display("FAIL exh_id: a=%0d b=%0d got id %0d expected %0d", a, b, got, id);
        end
      end
    end
  endtask

  task automatic test_contention();
    int got;
    logic [M-1:0] mask;
    for (int t = 0; t < 40; t++) begin
      mask = M'($urandom_range(1, (1 << M) - 1));
      run_txn(mask, BW'($urandom), BW'($urandom), int'($urandom_range(0, 3)), 1'b0, got);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    @(negedge clk); #1;
    test_reset();
    test_idle();
    test_round_robin();
    test_single();
    test_backpressure();
    test_idle();
    test_reset_in_run();
    test_zero();
    test_exhaustive();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits (N >= 2).
REQ-002 SHALL have parameter M, default 4, number of requesters (M >= 2); IW = max(1, $clog2(M)).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  M  per-requester request strobe.
REQ-006 SHALL have port req_a  input  M*N  requester i operand A at bits [i*N +: N].
REQ-007 SHALL have port req_b  input  M*N  requester i operand B at bits [i*N +: N].
REQ-008 SHALL have port req_ready  output  M  one-hot-or-zero grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_id  output  IW  index of the requester that owns the result.
REQ-011 SHALL have port rsp_p  output  2N  unsigned product.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts result when rsp_valid and rsp_ready are both high.

Function
REQ-013 SHALL arbitrate one shared unsigned shift-add multiplier among M requesters using round-robin priority.
REQ-014 SHALL use FSM states IDLE, LOAD, RUN, DONE.
REQ-015 SHALL assert req_ready only in IDLE, for the highest-priority requester with req_valid high: search starts at pointer rr_ptr and wraps modulo M.
REQ-016 SHALL, on accept, capture the operands and the requester index, set rr_ptr to (granted index + 1) mod M, and go to LOAD.
REQ-017 SHALL pulse the core load for one cycle in LOAD, then go to RUN.
REQ-018 SHALL stay in RUN for exactly N cycles, one shift-add step per cycle, then go to DONE.
REQ-019 SHALL hold rsp_valid high in DONE, with rsp_p and rsp_id stable, until rsp_ready is high; it then returns to IDLE.
REQ-020 SHALL give an accept-to-rsp_valid latency of N+2 cycles; the first rsp_valid cycle is the earliest cycle in which rsp_ready may complete the handshake.
REQ-021 SHALL hold rr_ptr unchanged and req_ready all-zero when no req_valid bit is set.
REQ-022 SHALL produce the exact product for all operands, including (2^N-1)*(2^N-1); the adder carry SHALL be kept (N+1 bits).
REQ-023 SHALL ignore req_valid and operand changes in every state other than IDLE.

Reset
REQ-024 SHALL, while rst_n is low: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, core registers cleared.
REQ-025 SHALL abort any in-flight operation when rst_n is asserted in LOAD, RUN or DONE; the result SHALL never be delivered.

Configuration
REQ-026 SHALL support macro MULT_ARBITER_ZERO_BYPASS_EN.
REQ-027 SHALL, with the macro defined, go straight from IDLE to DONE when the accepted req_a or req_b is 0, with rsp_p=0; the accept-to-rsp_valid latency is then 1 cycle.
REQ-028 SHALL, without the macro, treat zero operands like any other operands (latency N+2).

Structure
REQ-029 SHALL place the FSM state enum typedef and the state encodings in shared package mult_arbiter_pkg.
REQ-030 SHALL instantiate one sub-module, shift_add_core (inputs: load, operands; outputs: running shift-add product register), with the FSM and arbitration held in mult_arbiter.

Verification (N=4, M=4)
REQ-031 SHALL cover: single request, id 2, a=15, b=15 -> rsp_valid 6 cycles after accept, rsp_p=225, rsp_id=2.
REQ-032 SHALL cover: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0.
REQ-033 SHALL cover: a=7, b=9, rsp_ready low for 5 cycles -> rsp_valid, rsp_p=63 and rsp_id stay stable; req_ready stays 0 until handshake.
REQ-034 SHALL cover: rst_n pulsed low in RUN -> outputs zero immediately; after release, a new request 3*5 -> rsp_p=15 with no stale result delivered.
REQ-035 SHALL cover: with MULT_ARBITER_ZERO_BYPASS_EN defined, a=0, b=13 -> rsp_valid 1 cycle after accept, rsp_p=0; without it, latency is 6 cycles.
REQ-036 SHALL cover: exhaustive a,b in 0..15 from rotating requesters -> every rsp_p equals a*b and every rsp_id matches the issuing requester.
